// File: rtl/addr_signed_tmr_pipe.sv
// addr_signed_tmr_pipe
//   Signed WIDTH-bit adder producing a WIDTH+1-bit sum, built as a two-stage
//   valid/ready pipeline. Three redundant adder replicas are combined by a
//   bitwise majority voter. Saturating counters track corrected and
//   uncorrectable results, and a fault-injection port can corrupt one replica.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake; in_a, in_b signed operands
//   out_valid/out_ready   result handshake; out_sum voted signed sum
//   out_corr              exactly one replica disagreed and was outvoted
//   out_err               no two replicas agree; out_sum carries replica 0
//   fi_en/fi_sel/fi_mask  XOR fi_mask into replica fi_sel (3 = none)
//   clr_cnt               synchronous clear of counters and err_sticky
//   corr_cnt, err_cnt     saturating result counters
//   err_sticky            latched on any out_err handshake
module addr_signed_tmr_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_corr,
    output logic             out_err,
    input  logic             fi_en,
    input  logic [1:0]       fi_sel,
    input  logic [WIDTH:0]   fi_mask,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky
);

    function automatic logic signed [WIDTH:0] add_sxt(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH:0] a_x;
        logic signed [WIDTH:0] b_x;
        a_x = {a[WIDTH-1], a};
        b_x = {b[WIDTH-1], b};
        return a_x + b_x;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic                    s1_vld_q, s1_vld_d;
    logic signed [WIDTH-1:0] a_p1_q, a_p1_d;
    logic signed [WIDTH-1:0] b_p1_q, b_p1_d;
    logic                    s2_vld_q, s2_vld_d;
    logic signed [WIDTH:0]   sum_p2_q, sum_p2_d;
    logic                    corr_p2_q, corr_p2_d;
    logic                    err_p2_q, err_p2_d;
    logic [CNT_W-1:0]        corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
    logic                    sticky_q, sticky_d;

    logic                    s1_advance, s1_load, s2_load, out_hs;
    logic signed [WIDTH:0]   r0_sum, r1_sum, r2_sum, vote_sum;
    logic                    agree, pair;

    // Ready depends only on registered state and out_ready.
    assign s1_advance = !s2_vld_q || out_ready;
    assign in_ready   = !s1_vld_q || s1_advance;
    assign s1_load    = in_valid && in_ready;
    assign s2_load    = s1_vld_q && s1_advance;
    assign out_hs     = s2_vld_q && out_ready;

    // ---- stage 1 -> stage 2: replicas, fault injection and voting ----
    assign r0_sum = add_sxt(a_p1_q, b_p1_q) ^ ((fi_en && fi_sel == 2'd0) ? fi_mask : '0);
    assign r1_sum = add_sxt(a_p1_q, b_p1_q) ^ ((fi_en && fi_sel == 2'd1) ? fi_mask : '0);
    assign r2_sum = add_sxt(a_p1_q, b_p1_q) ^ ((fi_en && fi_sel == 2'd2) ? fi_mask : '0);

    assign vote_sum = (r0_sum & r1_sum) | (r0_sum & r2_sum) | (r1_sum & r2_sum);
    assign agree    = (r0_sum == r1_sum) && (r1_sum == r2_sum);
    assign pair     = (r0_sum == r1_sum) || (r0_sum == r2_sum) || (r1_sum == r2_sum);

    always_comb begin
        s1_vld_d  = s1_vld_q;
        a_p1_d    = a_p1_q;
        b_p1_d    = b_p1_q;
        s2_vld_d  = s2_vld_q;
        sum_p2_d  = sum_p2_q;
        corr_p2_d = corr_p2_q;
        err_p2_d  = err_p2_q;

        if (s1_load) begin
            a_p1_d = in_a;
            b_p1_d = in_b;
        end
        if (s1_advance || s1_load) begin
            s1_vld_d = s1_load;
        end

        if (s2_load) begin
            s2_vld_d  = 1'b1;
            sum_p2_d  = pair ? vote_sum : r0_sum;
            corr_p2_d = pair && !agree;
            err_p2_d  = !pair;
        end else if (out_hs) begin
            s2_vld_d  = 1'b0;
        end
    end

    // Counters advance once per output handshake; a clear in the same cycle wins.
    always_comb begin
        corr_cnt_d = corr_cnt_q;
        err_cnt_d  = err_cnt_q;
        sticky_d   = sticky_q || (out_hs && err_p2_q);
        if (clr_cnt) begin
            corr_cnt_d = '0;
            err_cnt_d  = '0;
            sticky_d   = out_hs && err_p2_q;
        end else if (out_hs) begin
            if (corr_p2_q) corr_cnt_d = sat_inc(corr_cnt_q);
            if (err_p2_q)  err_cnt_d  = sat_inc(err_cnt_q);
        end
    end

    // ---- stage 1 registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
        end
        a_p1_q <= a_p1_d;
        b_p1_q <= b_p1_d;
    end

    // ---- stage 2 registers and counters ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld_q   <= 1'b0;
            sum_p2_q   <= '0;
            corr_p2_q  <= 1'b0;
            err_p2_q   <= 1'b0;
            corr_cnt_q <= '0;
            err_cnt_q  <= '0;
            sticky_q   <= 1'b0;
        end else begin
            s2_vld_q   <= s2_vld_d;
            sum_p2_q   <= sum_p2_d;
            corr_p2_q  <= corr_p2_d;
            err_p2_q   <= err_p2_d;
            corr_cnt_q <= corr_cnt_d;
            err_cnt_q  <= err_cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    assign out_valid  = s2_vld_q;
    assign out_sum    = sum_p2_q;
    assign out_corr   = corr_p2_q;
    assign out_err    = err_p2_q;
    assign corr_cnt   = corr_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign err_sticky = sticky_q;

endmodule
